frame_swap_ctrl: RTL
====================

Name: frame_swap_ctrl

Overview:
- Double-buffer scheduler between the frame builder (memory_manage, writer) and top_vector_display (reader) sharing one template_ram.
- RAM is split into two pages of PAGE_DEPTH entries; the block owns which page is front (drawn) and which is back (built).
- Issues build and draw commands, and swaps pages only when both sides are finished, so the display never reads a half-built frame.

Parameters:
- ADDRESSWIDTH, 16, width of RAM base/length buses.
- PAGE_DEPTH, 500, entries per page; page 0 base = 0, page 1 base = PAGE_DEPTH.
- TIMEOUT_CYCLES, 100000, draw watchdog limit in clk cycles (used only with optional feature).

Ports:
- clk  in  1  system clock (clk100MHz domain).
- rst  in  1  asynchronous, active-low reset.
- build_start  out  1  one-cycle pulse: builder may fill page at wr_base.
- build_done  in  1  one-cycle pulse: back page complete.
- build_len  in  ADDRESSWIDTH  entries written; sampled when build_done=1.
- go  out  1  one-cycle pulse: display starts drawing page at rd_base.
- halt  in  1  one-cycle pulse: display finished current frame.
- wr_base  out  ADDRESSWIDTH  back-page base address.
- rd_base  out  ADDRESSWIDTH  front-page base address.
- front_len  out  ADDRESSWIDTH  valid entries in front page.
- frame_cnt  out  16  completed swaps.
- overrun  out  1  sticky: a build_len exceeded PAGE_DEPTH.
- draw_timeout  out  1  sticky watchdog flag (tied 0 without feature).

Behaviour:
- Reset (rst=0, asynchronous): state=S_INIT; back_sel=0; wr_base=0; rd_base=PAGE_DEPTH; front_len=0; frame_cnt=0; go=0; build_start=0; overrun=0; draw_timeout=0; build_busy=0; draw_busy=0. All outputs are registered.
- wr_base = back_sel ? PAGE_DEPTH : 0. rd_base is the other base. Both change only in S_SWAP.
- States:
  - S_INIT: first cycle after reset release, pulse build_start and set build_busy. Go to S_FIRST.
  - S_FIRST: wait for build_done with build_busy=1. Then:
    - build_len==0: discard, pulse build_start next cycle, stay.
    - otherwise: go to S_SWAP.
  - S_RUN: draw and build proceed concurrently.
    - halt while draw_busy: clear draw_busy.
    - build_done while build_busy: clear build_busy and latch the length.
      - If the length is 0: discard and re-pulse build_start next cycle.
    - When !draw_busy && !build_busy (latched length nonzero): go to S_SWAP.
    - When !draw_busy && build_busy: redisplay the same front page; pulse go the next cycle and set draw_busy.
  - S_SWAP (1 cycle):
    - toggle back_sel; front_len = min(latched length, PAGE_DEPTH).
    - set overrun if length > PAGE_DEPTH.
    - frame_cnt += 1, wrapping 16'hFFFF -> 0.
    - Next cycle (entering S_RUN): pulse go and build_start together; set draw_busy and build_busy.
- Latency:
  - last of {halt, build_done} -> S_SWAP: 1 cycle.
  - S_SWAP -> go/build_start: 1 cycle.
  - halt -> redisplay go: 1 cycle.
- Simultaneous halt and build_done in the same cycle: both cleared that cycle, swap proceeds (no redisplay).
- Spurious events: halt with draw_busy=0, or build_done with build_busy=0, is ignored with no state change.
- go and build_start are never asserted for more than one consecutive cycle.
- rst asserted mid-frame aborts immediately to reset values. The builder and display share rst.

Optional Feature:
- Macro FRAME_SWAP_WATCHDOG_EN.
- Defined:
  - a counter clears on each go and increments while draw_busy.
  - Reaching TIMEOUT_CYCLES-1 without halt sets sticky draw_timeout and is treated as halt on that cycle.
- Undefined: no counter; draw_timeout tied 0; the block waits for halt indefinitely.

Test Plan:
- Reset release, builder returns build_done with build_len=120 at cycle 10:
  - build_start at cycle 1; S_SWAP at cycle 11.
  - cycle 12: go and build_start pulse, rd_base=0, wr_base=500, front_len=120, frame_cnt=1.
- Slow builder: halt arrives twice before build_done(len=80):
  - go re-pulses 1 cycle after each halt, with rd_base unchanged.
  - After build_done and the next halt, swap: rd_base=500, front_len=80, frame_cnt=2.
- halt and build_done(len=50) in the same cycle: exactly one swap, no redisplay go, go asserted 2 cycles later.
- build_len=0 then build_len=700:
  - the first is discarded and build_start is re-pulsed with no swap.
  - the second swaps with front_len=500 and overrun=1 (sticky through later frames).
- Spurious halt in S_FIRST, and rst=0 asserted mid-S_RUN:
  - no state change from the spurious halt.
  - all outputs return to reset values asynchronously; after release build_start pulses again.
- With FRAME_SWAP_WATCHDOG_EN and TIMEOUT_CYCLES=20, halt withheld: draw_timeout=1 twenty cycles after go, followed by swap or redisplay per build state.

Source files
------------

// File: rtl/frame_swap_ctrl.sv
// Double-buffer page scheduler between the frame builder (writer) and the vector display (reader).
// Optional draw watchdog enabled by defining FRAME_SWAP_WATCHDOG_EN.
module frame_swap_ctrl #(
  parameter int ADDRESSWIDTH   = 16,
  parameter int PAGE_DEPTH     = 500,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    build_start,
  input  logic                    build_done,
  input  logic [ADDRESSWIDTH-1:0] build_len,
  output logic                    go,
  input  logic                    halt,
  output logic [ADDRESSWIDTH-1:0] wr_base,
  output logic [ADDRESSWIDTH-1:0] rd_base,
  output logic [ADDRESSWIDTH-1:0] front_len,
  output logic [15:0]             frame_cnt,
  output logic                    overrun,
  output logic                    draw_timeout
);

  // state   | meaning
  // S_INIT  | first cycle after reset: kick off the first build
  // S_FIRST | waiting for the first non-empty frame, nothing on screen yet
  // S_RUN   | display draws front page while builder fills back page
  // S_SWAP  | exchange pages, publish new front length, count the frame
  typedef enum logic [1:0] {S_INIT, S_FIRST, S_RUN, S_SWAP} state_t;

  localparam logic [ADDRESSWIDTH-1:0] PAGE1_BASE = ADDRESSWIDTH'(PAGE_DEPTH);
  localparam logic [ADDRESSWIDTH-1:0] PAGE0_BASE = '0;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("frame_swap_ctrl: TIMEOUT_CYCLES must be at least 2");
  end

  state_t                  state;
  logic                    back_sel;
  logic                    build_busy;
  logic                    draw_busy;
  logic                    rebuild_pend;
  logic [ADDRESSWIDTH-1:0] len_lat;

  logic wd_hit;
  logic halt_ok;
  logic done_ok;
  logic len_zero;
  logic draw_busy_nx;
  logic build_busy_nx;

`ifdef FRAME_SWAP_WATCHDOG_EN
  localparam int                WD_W     = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0]   WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);
  logic [WD_W-1:0] wd_cnt;
  assign wd_hit = (state == S_RUN) && draw_busy && (wd_cnt == WD_LIMIT);
`else
  assign wd_hit = 1'b0;
`endif

  // A watchdog expiry stands in for halt; a zero-length build keeps the builder busy.
  assign halt_ok       = (halt | wd_hit) & draw_busy;
  assign done_ok       = build_done & build_busy;
  assign len_zero      = (build_len == '0);
  assign draw_busy_nx  = draw_busy & ~halt_ok;
  assign build_busy_nx = build_busy & ~(done_ok & ~len_zero);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_INIT;
      back_sel     <= 1'b0;
      wr_base      <= PAGE0_BASE;
      rd_base      <= PAGE1_BASE;
      front_len    <= '0;
      frame_cnt    <= '0;
      go           <= 1'b0;
      build_start  <= 1'b0;
      overrun      <= 1'b0;
      draw_timeout <= 1'b0;
      build_busy   <= 1'b0;
      draw_busy    <= 1'b0;
      rebuild_pend <= 1'b0;
      len_lat      <= '0;
`ifdef FRAME_SWAP_WATCHDOG_EN
      wd_cnt       <= '0;
`endif
    end else begin
      go          <= 1'b0;
      build_start <= 1'b0;
      // A re-request colliding with a live build_start pulse is held one cycle.
      if (rebuild_pend && !build_start) begin
        build_start  <= 1'b1;
        rebuild_pend <= 1'b0;
      end

      case (state)
        S_INIT: begin
          build_start <= 1'b1;
          build_busy  <= 1'b1;
          state       <= S_FIRST;
        end

        S_FIRST: begin
          if (done_ok) begin
            if (len_zero) begin
              if (build_start) rebuild_pend <= 1'b1;
              else             build_start  <= 1'b1;
            end else begin
              len_lat    <= build_len;
              build_busy <= 1'b0;
              state      <= S_SWAP;
            end
          end
        end

        S_RUN: begin
          draw_busy  <= draw_busy_nx;
          build_busy <= build_busy_nx;
`ifdef FRAME_SWAP_WATCHDOG_EN
          if (draw_busy && !wd_hit) wd_cnt <= wd_cnt + 1'b1;
`endif
          if (wd_hit && !halt) draw_timeout <= 1'b1;
          if (done_ok) begin
            if (len_zero) begin
              if (build_start) rebuild_pend <= 1'b1;
              else             build_start  <= 1'b1;
            end else begin
              len_lat <= build_len;
            end
          end
          if (!draw_busy_nx && !build_busy_nx) begin
            state <= S_SWAP;
          end else if (!draw_busy_nx && !go) begin
            // Builder still busy: show the same front page again.
            go        <= 1'b1;
            draw_busy <= 1'b1;
`ifdef FRAME_SWAP_WATCHDOG_EN
            wd_cnt    <= '0;
`endif
          end
        end

        S_SWAP: begin
          back_sel    <= ~back_sel;
          wr_base     <= back_sel ? PAGE0_BASE : PAGE1_BASE;
          rd_base     <= back_sel ? PAGE1_BASE : PAGE0_BASE;
          front_len   <= (len_lat > PAGE1_BASE) ? PAGE1_BASE : len_lat;
          if (len_lat > PAGE1_BASE) overrun <= 1'b1;
          frame_cnt   <= frame_cnt + 16'd1;
          go          <= 1'b1;
          build_start <= 1'b1;
          draw_busy   <= 1'b1;
          build_busy  <= 1'b1;
          state       <= S_RUN;
`ifdef FRAME_SWAP_WATCHDOG_EN
          wd_cnt      <= '0;
`endif
        end

        default: state <= S_INIT;
      endcase
    end
  end

endmodule
